// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter feeding the 7-segment scan mux.
// Values above MAX_VAL saturate and raise overflow. bcd_int only changes on the completing edge.

module bin2bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
    parameter int BIN_W   = 14,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic                  fpga_clk,
    input  logic                  sys_init_ctrl_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  bin_valid,
    output logic                  bin_ready,
    output logic [4*DIGITS-1:0]   bcd_int,
    output logic                  bcd_valid,
    output logic                  overflow
);
    localparam int BCD_W = 4*DIGITS;
    localparam int CNT_W = $clog2(BIN_W+1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_adj;
    logic [BCD_W-1:0] acc_next;
    logic [BIN_W-1:0] bin_sr;
    logic [BIN_W-1:0] bin_next;
    logic [CNT_W-1:0] cnt;
    logic             pend_ovf;
    logic             carry_out;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bin2bcd_add3 u_add3 (
                .d (acc[4*g +: 4]),
                .q (acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // A bit leaving the top digit would mean MAX_VAL exceeds the digit range; report it as overflow.
    assign {carry_out, acc_next} = {acc_adj, bin_sr[BIN_W-1]};
    assign bin_next              = {bin_sr[BIN_W-2:0], 1'b0};
    assign bin_ready             = (state == IDLE);

    always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
        if (!sys_init_ctrl_n) begin
            state     <= IDLE;
            acc       <= '0;
            bin_sr    <= '0;
            cnt       <= '0;
            pend_ovf  <= 1'b0;
            bcd_int   <= '0;
            bcd_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bin_valid) begin
                        if (bin_in > MAX_BIN) begin
                            bin_sr   <= MAX_BIN;
                            pend_ovf <= 1'b1;
                        end else begin
                            bin_sr   <= bin_in;
                            pend_ovf <= 1'b0;
                        end
                        acc   <= '0;
                        cnt   <= CNT_LOAD;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc    <= acc_next;
                    bin_sr <= bin_next;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        bcd_int   <= acc_next;
                        overflow  <= pend_ovf | carry_out;
                        bcd_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    bcd_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    bcd_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: decimal reference model, per-cycle handshake timing model.
module tb_bin2bcd_seq;
    localparam int BIN_W   = 14;
    localparam int DIGITS  = 4;
    localparam int MAX_VAL = 9999;

    logic              fpga_clk = 1'b0;
    logic              rst_n    = 1'b0;
    logic              bin_valid = 1'b0;
    logic [BIN_W-1:0]  bin_in   = '0;
    logic              bin_ready;
    logic [15:0]       bcd_int;
    logic              bcd_valid;
    logic              overflow;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          model_busy = 0;
    int          accepts = 0;
    logic [15:0] hold_bcd = '0;
    logic        hold_ovf = 1'b0;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .MAX_VAL(MAX_VAL)) dut (
        .fpga_clk        (fpga_clk),
        .sys_init_ctrl_n (rst_n),
        .bin_in          (bin_in),
        .bin_valid       (bin_valid),
        .bin_ready       (bin_ready),
        .bcd_int         (bcd_int),
        .bcd_valid       (bcd_valid),
        .overflow        (overflow)
    );

    always #5 fpga_clk = ~fpga_clk;

    function automatic exp_t ref_model(input int v);
        exp_t r;
        int   s;
        int   p;
        s     = (v > MAX_VAL) ? MAX_VAL : v;
        r.ovf = (v > MAX_VAL);
        r.bcd = '0;
        p     = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r.bcd[4*i +: 4] = 4'((s / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timing model: accept in idle, then busy for BIN_W shift cycles plus the done cycle.
    initial forever begin
        @(posedge fpga_clk or negedge rst_n);
        if (!rst_n) begin
            model_busy = 0;
            exp_q.delete();
            hold_bcd = '0;
            hold_ovf = 1'b0;
        end else if (model_busy > 0) begin
            model_busy--;
        end else if (bin_valid) begin
            exp_q.push_back(ref_model(int'(bin_in)));
            model_busy = BIN_W + 1;
            accepts++;
        end
    end

    // Monitor: pops the scoreboard on every bcd_valid, otherwise checks outputs are held.
    initial forever begin
        exp_t e;
        @(negedge fpga_clk);
        if (rst_n) check("bin_ready", 32'(bin_ready), 32'(model_busy == 0));
        check("bcd_valid", 32'(bcd_valid), 32'(rst_n && model_busy == 1));
        if (bcd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bcd_valid: got bcd_int %0h expected no result at %0t", bcd_int, $time);
            end else begin
                e = exp_q.pop_front();
                check("bcd_int", 32'(bcd_int), 32'(e.bcd));
                check("overflow", 32'(overflow), 32'(e.ovf));
                hold_bcd = e.bcd;
                hold_ovf = e.ovf;
            end
        end else begin
            check("bcd_hold", 32'(bcd_int), 32'(hold_bcd));
            check("ovf_hold", 32'(overflow), 32'(hold_ovf));
        end
    end

    task automatic send(input int v);
        int a0;
        int n;
        @(negedge fpga_clk);
        bin_in    = BIN_W'(v);
        bin_valid = 1'b1;
        a0 = accepts;
        n  = 0;
        while (accepts == a0 && n < 100) begin
            @(negedge fpga_clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept of %0d", v);
        end
        bin_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((model_busy != 0 || exp_q.size() != 0) && n < 100) begin
            @(negedge fpga_clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy %0d expected 0", model_busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dir_vals[6];
        dir_vals = '{0, 1234, 9999, 10, 12000, 42};
        repeat (3) @(negedge fpga_clk);
        rst_n = 1'b1;

        foreach (dir_vals[i]) begin
            send(dir_vals[i]);
            wait_idle();
        end

        // Continuous valid with a changing value: only idle-edge values are converted.
        @(negedge fpga_clk);
        bin_valid = 1'b1;
        repeat (200) begin
            bin_in = BIN_W'($urandom_range(0, 16383));
            @(negedge fpga_clk);
        end
        bin_valid = 1'b0;
        wait_idle();

        repeat (20) begin
            send(int'($urandom_range(0, 16383)));
            repeat ($urandom_range(0, 20)) @(negedge fpga_clk);
        end
        wait_idle();

        // Abandon a conversion with an asynchronous reset in the 5th shift cycle.
        send(5678);
        repeat (4) @(negedge fpga_clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge fpga_clk);
        #2 rst_n = 1'b1;
        @(negedge fpga_clk);
        check("rst_bcd", 32'(bcd_int), 32'h0);
        check("rst_ready", 32'(bin_ready), 32'h1);
        repeat (20) @(negedge fpga_clk);

        send(77);
        wait_idle();
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter that sits directly upstream of the 7-segment scan multiplexer. It produces that stage's 16-bit, four-digit BCD input. It accepts an unsigned binary value over a valid/ready handshake and runs an iterative double-dabble (add-3/shift) conversion, one bit per clock. It then presents a stable, registered BCD word that holds until the next conversion completes.

Parameters:
BIN_W, 14, width of binary input; 14 bits covers 0..9999.
DIGITS, 4, number of BCD digits produced; bcd_int width = 4*DIGITS.
MAX_VAL, 9999, saturation limit, equal to 10^DIGITS - 1.

Ports:
fpga_clk  input  1  system clock; all state changes on its rising edge.
sys_init_ctrl_n  input  1  asynchronous, active-low reset.
bin_in  input  BIN_W  unsigned binary value to convert.
bin_valid  input  1  bin_in is valid this cycle.
bin_ready  output  1  block can accept a value; high only in IDLE.
bcd_int  output  4*DIGITS  registered BCD result; digit 0 in [3:0], digit 3 in [15:12].
bcd_valid  output  1  one-cycle pulse when bcd_int has just updated.
overflow  output  1  set when the last accepted input exceeded MAX_VAL; updates together with bcd_int.

Behaviour:
- Clock and reset are decided as follows: one clock, fpga_clk. Reset sys_init_ctrl_n is asynchronous and active-low.
- Reset values: state=IDLE, bin_ready=1 once reset is released, bcd_int=0, bcd_valid=0, overflow=0. The shift register and bit counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - bin_ready=1.
  - On an edge where bin_valid=1, the input is accepted.
  - If bin_in > MAX_VAL, the shift register loads MAX_VAL and the pending-overflow bit is set. Otherwise it loads bin_in and pending-overflow is cleared.
  - The BCD accumulator is cleared, the bit counter is set to BIN_W, and the state goes to SHIFT.
- SHIFT:
  - bin_ready=0.
  - Each cycle, every 4-bit accumulator digit >= 5 first has 3 added. The combined {accumulator, binary} register is then shifted left by one, MSB of the binary part first. The counter decrements.
  - When the counter reaches 1 on a shift edge, that edge performs the final shift. The same edge loads bcd_int from the post-shift accumulator and loads overflow from pending-overflow. It also sets bcd_valid=1 and moves the state to DONE.
  - Add-3 is evaluated on the pre-shift value only; no add-3 is applied after the final shift.
- DONE:
  - bin_ready=0 and bcd_valid=1 for exactly this one cycle.
  - The next edge moves to IDLE and clears bcd_valid.
- Latency: bcd_valid is visible in the cycle following the BIN_W-th edge after the accept edge (14 edges by default). Throughput is one conversion per BIN_W+2 cycles.
- bcd_int and overflow hold their values at all times except the completing edge, so the downstream display never sees a partial result.
- bin_valid while bin_ready=0 is ignored. No queuing; the upstream source must hold or re-present its value.
- bin_valid held continuously high: a new accept occurs on the first IDLE edge after DONE.
- Reset asserted mid-SHIFT or in DONE: the conversion is abandoned immediately and all outputs return to reset values. No bcd_valid pulse follows.
- Every digit of bcd_int is always 0..9. No X propagation: every register has a reset value.

Test Plan:
- Reset, then bin_in=0 with bin_valid for 1 cycle -> after 14 edges bcd_int=16'h0000, bcd_valid high for 1 cycle, overflow=0, bin_ready returns high the next cycle.
- bin_in=1234 -> bcd_int=16'h1234 on the 14th edge after accept; bin_ready low for exactly 15 cycles.
- bin_in=9999, then bin_in=10 -> bcd_int=16'h9999, then 16'h0010; overflow=0 throughout.
- bin_in=12000 -> bcd_int=16'h9999, overflow=1. A following bin_in=42 gives bcd_int=16'h0042 and overflow=0.
- bin_valid held high with bin_in changing every cycle -> only the values present on IDLE accept edges are converted; back-to-back bcd_valid pulses are spaced 16 cycles apart.
- Start bin_in=5678, assert sys_init_ctrl_n low asynchronously at the 5th SHIFT cycle, release 3 cycles later -> bcd_int=0, no bcd_valid pulse, bin_ready=1 on the first cycle after release.
